// File: rtl/digit_counter_n_if.sv
// Control and display bundle of one counter digit: gate, tick, preset and mode in;
// registered digit, wrap strobe, saturation flag and 7-segment lines out.
interface digit_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             G;
  logic             A;
  logic             TICK;
  logic             P;
  logic             UP;
  logic             HOLD_AT_END;
  logic [WIDTH-1:0] VALUE;
  logic             TC_OUT;
  logic             END_FLAG;
  logic             aus, bus, cus, dus, eus, fus, gus;

  modport master (
    output G, A, TICK, P, UP, HOLD_AT_END,
    input  VALUE, TC_OUT, END_FLAG, aus, bus, cus, dus, eus, fus, gus
  );

  modport slave (
    input  G, A, TICK, P, UP, HOLD_AT_END,
    output VALUE, TC_OUT, END_FLAG, aus, bus, cus, dus, eus, fus, gus
  );
endinterface

// File: rtl/digit_counter_n.sv
// Synchronous modulo-N up/down digit with preset, saturate-at-end mode and 7-segment decode.
// Cascades via a registered one-cycle TC_OUT strobe into the next stage's TICK.
module digit_counter_n #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4,
  parameter int PRESET  = 9
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  digit_counter_n_if.slave bus_if
);
  localparam logic [0:0]       ST_RUN = 1'b0;
  localparam logic [0:0]       ST_SAT = 1'b1;
  localparam logic [WIDTH-1:0] V_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] V_ZERO = '0;
  localparam logic [WIDTH-1:0] V_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] V_PRE  = WIDTH'(PRESET);

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] next_val, term_val;
  logic             tc_q, tc_d;
  logic [0:0]       state_q, state_d;
  logic             step;
  logic [6:0]       seg;

  assign step = bus_if.TICK & (bus_if.G | bus_if.A);

  // Wrap is an explicit compare so non-power-of-two moduli never rely on overflow.
  always_comb begin
    term_val = bus_if.UP ? V_MAX : V_ZERO;
    if (bus_if.UP) begin
      next_val = (value_q == V_MAX) ? V_ZERO : value_q + V_ONE;
    end else begin
      next_val = (value_q == V_ZERO) ? V_MAX : value_q - V_ONE;
    end
  end

  always_comb begin
    value_d = value_q;
    state_d = state_q;
    tc_d    = 1'b0;
    if (bus_if.P) begin
      value_d = V_PRE;
      state_d = ST_RUN;
    end else if (state_q == ST_SAT) begin
      if (!bus_if.HOLD_AT_END) begin
        state_d = ST_RUN;
      end
    end else if (step) begin
      if (bus_if.HOLD_AT_END) begin
        // Sitting on the terminal value (e.g. after a preset) saturates without moving.
        if (value_q != term_val) begin
          value_d = next_val;
        end
        if ((value_q == term_val) || (next_val == term_val)) begin
          state_d = ST_SAT;
        end
      end else begin
        value_d = next_val;
        tc_d    = (value_q == term_val);
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      value_q <= '0;
      tc_q    <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      value_q <= value_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  // Segment order {a,b,c,d,e,f,g}, active-high.
  always_comb begin
    seg = 7'b0000000;
    case (int'(value_q))
      0:       seg = 7'b1111110;
      1:       seg = 7'b0110000;
      2:       seg = 7'b1101101;
      3:       seg = 7'b1111001;
      4:       seg = 7'b0110011;
      5:       seg = 7'b1011011;
      6:       seg = 7'b1011111;
      7:       seg = 7'b1110000;
      8:       seg = 7'b1111111;
      9:       seg = 7'b1111011;
      10:      seg = 7'b1110111;
      11:      seg = 7'b0011111;
      12:      seg = 7'b1001110;
      13:      seg = 7'b0111101;
      14:      seg = 7'b1001111;
      15:      seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end

  assign bus_if.VALUE    = value_q;
  assign bus_if.TC_OUT   = tc_q;
  assign bus_if.END_FLAG = (state_q == ST_SAT);
  assign {bus_if.aus, bus_if.bus, bus_if.cus, bus_if.dus,
          bus_if.eus, bus_if.fus, bus_if.gus} = seg;
endmodule

// File: tb/tb_digit_counter_n.sv
// Bench: a units digit (mod 10) whose wrap strobe cascades into a tens digit (mod 6),
// checked every cycle against an arithmetic model plus literal expectations.
module tb_digit_counter_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick1 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  digit_counter_n_if #(.WIDTH(4)) if0 ();
  digit_counter_n_if #(.WIDTH(3)) if1 ();

  assign if1.TICK = if0.TC_OUT | tick1;

  digit_counter_n #(.MODULUS(10), .WIDTH(4), .PRESET(9)) u0 (
    .CLK_IN(clk), .RST_N(rst_n), .bus_if(if0.slave));
  digit_counter_n #(.MODULUS(6), .WIDTH(3), .PRESET(3)) u1 (
    .CLK_IN(clk), .RST_N(rst_n), .bus_if(if1.slave));

  // Reference model state per instance.
  int   m_val [2] = '{0, 0};
  logic m_tc  [2] = '{1'b0, 1'b0};
  logic m_sat [2] = '{1'b0, 1'b0};
  logic cas_t;

  string seg_tab [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input int v);
    logic [6:0] r;
    string      s;
    r = '0;
    s = seg_tab[v];
    for (int i = 0; i < s.len(); i++) begin
      r[6 - (int'(s[i]) - 97)] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mstep(input int k, input logic g, input logic a, input logic t,
                       input logic p, input logic up, input logic hold);
    int md, pre, term, nv;
    md   = (k == 0) ? 10 : 6;
    pre  = (k == 0) ? 9 : 3;
    term = up ? md - 1 : 0;
    m_tc[k] = 1'b0;
    if (p) begin
      m_val[k] = pre;
      m_sat[k] = 1'b0;
    end else if (m_sat[k]) begin
      if (!hold) m_sat[k] = 1'b0;
    end else if (t && (g || a)) begin
      if (hold && m_val[k] == term) begin
        m_sat[k] = 1'b1;
      end else begin
        nv = up ? (m_val[k] + 1) % md : (m_val[k] + md - 1) % md;
        if (!hold) m_tc[k] = (m_val[k] == term);
        m_val[k] = nv;
        if (hold && nv == term) m_sat[k] = 1'b1;
      end
    end
  endtask

  always @(negedge rst_n) begin
    m_val = '{0, 0};
    m_tc  = '{1'b0, 1'b0};
    m_sat = '{1'b0, 1'b0};
  end

  always @(posedge clk) begin
    if (rst_n) begin
      cas_t = m_tc[0] | tick1;
      mstep(0, if0.G, if0.A, if0.TICK, if0.P, if0.UP, if0.HOLD_AT_END);
      mstep(1, if1.G, if1.A, cas_t, if1.P, if1.UP, if1.HOLD_AT_END);
    end
    #1;
    chk("m_value0", 32'(if0.VALUE), 32'(m_val[0]));
    chk("m_tc0", 32'(if0.TC_OUT), 32'(m_tc[0]));
    chk("m_end0", 32'(if0.END_FLAG), 32'(m_sat[0]));
    chk("m_seg0", 32'({if0.aus, if0.bus, if0.cus, if0.dus, if0.eus, if0.fus, if0.gus}),
        32'(seg_of(m_val[0])));
    chk("m_value1", 32'(if1.VALUE), 32'(m_val[1]));
    chk("m_tc1", 32'(if1.TC_OUT), 32'(m_tc[1]));
    chk("m_end1", 32'(if1.END_FLAG), 32'(m_sat[1]));
    chk("m_seg1", 32'({if1.aus, if1.bus, if1.cus, if1.dus, if1.eus, if1.fus, if1.gus}),
        32'(seg_of(m_val[1])));
  end

  function automatic logic [31:0] seg0();
    return 32'({if0.aus, if0.bus, if0.cus, if0.dus, if0.eus, if0.fus, if0.gus});
  endfunction

  function automatic logic [31:0] seg1();
    return 32'({if1.aus, if1.bus, if1.cus, if1.dus, if1.eus, if1.fus, if1.gus});
  endfunction

  task automatic clk1();
    @(posedge clk);
    #2;
  endtask

  task automatic tick0_once();
    if0.TICK = 1'b1;
    clk1();
    if0.TICK = 1'b0;
  endtask

  task automatic tick1_once();
    tick1 = 1'b1;
    clk1();
    tick1 = 1'b0;
  endtask

  initial begin
    if0.G = 1'b0; if0.A = 1'b0; if0.TICK = 1'b0; if0.P = 1'b0; if0.UP = 1'b1; if0.HOLD_AT_END = 1'b0;
    if1.G = 1'b0; if1.A = 1'b0; if1.P = 1'b0; if1.UP = 1'b1; if1.HOLD_AT_END = 1'b0;
    #2;
    chk("rst_value0", 32'(if0.VALUE), 0);
    chk("rst_tc0", 32'(if0.TC_OUT), 0);
    chk("rst_end0", 32'(if0.END_FLAG), 0);
    chk("rst_seg0", seg0(), 32'h7E);
    chk("rst_seg1", seg1(), 32'h7E);
    @(negedge clk);
    rst_n = 1'b1;
    clk1();

    // Up-count wrap, cascading into the tens digit one cycle later.
    if0.G = 1'b1; if1.G = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick0_once();
      chk("upwrap_value", 32'(if0.VALUE), 32'(i % 10));
      chk("upwrap_tc", 32'(if0.TC_OUT), (i == 10) ? 1 : 0);
      if (i == 10) begin
        chk("upwrap_seg0", seg0(), 32'h7E);
        chk("cascade_before", 32'(if1.VALUE), 0);
      end
      clk1();
    end
    chk("cascade_after", 32'(if1.VALUE), 1);
    chk("cascade_tc_gone", 32'(if0.TC_OUT), 0);

    // Gate closed: ticks ignored; preset still loads.
    if0.G = 1'b0; if0.A = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick0_once();
      chk("gated_value", 32'(if0.VALUE), 0);
      chk("gated_tc", 32'(if0.TC_OUT), 0);
    end
    if0.P = 1'b1; clk1(); if0.P = 1'b0;
    chk("preset_value", 32'(if0.VALUE), 9);
    chk("preset_seg", seg0(), 32'h7B);

    // Down-count wrap and preset/tick collision.
    if0.A = 1'b1;
    tick0_once();
    chk("up_from9", 32'(if0.VALUE), 0);
    clk1();
    if0.UP = 1'b0;
    tick0_once();
    chk("down_wrap_value", 32'(if0.VALUE), 9);
    chk("down_wrap_tc", 32'(if0.TC_OUT), 1);
    clk1();
    if0.P = 1'b1; if0.TICK = 1'b1;
    clk1();
    if0.P = 1'b0; if0.TICK = 1'b0;
    chk("collide_value", 32'(if0.VALUE), 9);
    chk("collide_tc", 32'(if0.TC_OUT), 0);

    // Hold mode: saturate at 9 without a wrap strobe.
    if0.UP = 1'b1;
    tick0_once();
    clk1();
    if0.HOLD_AT_END = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick0_once();
      chk("hold_value", 32'(if0.VALUE), 32'(i));
      chk("hold_end", 32'(if0.END_FLAG), (i == 9) ? 1 : 0);
      chk("hold_tc", 32'(if0.TC_OUT), 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick0_once();
      chk("sat_value", 32'(if0.VALUE), 9);
      chk("sat_end", 32'(if0.END_FLAG), 1);
    end
    if0.P = 1'b1; clk1(); if0.P = 1'b0;
    chk("sat_preset_value", 32'(if0.VALUE), 9);
    chk("sat_preset_end", 32'(if0.END_FLAG), 0);
    tick0_once();
    chk("preset_term_value", 32'(if0.VALUE), 9);
    chk("preset_term_end", 32'(if0.END_FLAG), 1);
    chk("preset_term_tc", 32'(if0.TC_OUT), 0);
    if0.HOLD_AT_END = 1'b0;
    clk1();
    chk("hold_release_end", 32'(if0.END_FLAG), 0);
    tick0_once();
    chk("after_release_value", 32'(if0.VALUE), 0);
    chk("after_release_tc", 32'(if0.TC_OUT), 1);
    clk1();

    // Tens digit (mod 6): 3 -> 5 -> wrap to 0.
    if1.P = 1'b1; clk1(); if1.P = 1'b0;
    chk("tens_preset", 32'(if1.VALUE), 3);
    tick1_once(); tick1_once();
    chk("tens_five", 32'(if1.VALUE), 5);
    chk("tens_five_seg", seg1(), 32'h5B);
    tick1_once();
    chk("tens_wrap_value", 32'(if1.VALUE), 0);
    chk("tens_wrap_tc", 32'(if1.TC_OUT), 1);
    clk1();

    // Randomised traffic, checked by the per-cycle model.
    for (int n = 0; n < 1500; n++) begin
      if0.G = ($urandom % 4) != 0;
      if0.A = ($urandom % 4) == 0;
      if0.TICK = $urandom % 2;
      if0.P = ($urandom % 16) == 0;
      if ($urandom % 8 == 0) if0.UP = ~if0.UP;
      if ($urandom % 24 == 0) if0.HOLD_AT_END = ~if0.HOLD_AT_END;
      if1.G = ($urandom % 3) != 0;
      if1.A = ($urandom % 5) == 0;
      tick1 = ($urandom % 3) == 0;
      if1.P = ($urandom % 20) == 0;
      if ($urandom % 8 == 0) if1.UP = ~if1.UP;
      if ($urandom % 24 == 0) if1.HOLD_AT_END = ~if1.HOLD_AT_END;
      clk1();
    end
    if0.TICK = 1'b0; if0.P = 1'b0; tick1 = 1'b0; if1.P = 1'b0;
    if0.HOLD_AT_END = 1'b0; if0.G = 1'b1;
    clk1();

    // Asynchronous reset between edges at VALUE=7.
    if0.P = 1'b1; clk1(); if0.P = 1'b0;
    if0.UP = 1'b0;
    tick0_once(); tick0_once();
    chk("pre_reset_value", 32'(if0.VALUE), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_value", 32'(if0.VALUE), 0);
    chk("async_rst_end", 32'(if0.END_FLAG), 0);
    chk("async_rst_seg", seg0(), 32'h7E);
    @(negedge clk);
    rst_n = 1'b1;
    clk1();
    clk1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
